// File: rtl/pe_r_iter.sv
// RAVEN systolic PE. It has a single-cycle GEMM MAC with a weight pass-through and a
// multi-cycle Horner engine (acc <- acc*v + c_k) for the unary operations.
module pe_r_iter #(
   parameter int INT_BW   = 5,
   parameter int FRA_BW   = 7,
   parameter int MUL_BW   = 16,
   parameter int ACC_BW   = 32,
   parameter int ITER_MAX = 8,
   parameter int CNT_BW   = $clog2(ITER_MAX + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [1:0]        gemm_uno,
   input  logic              start_i,
   input  logic [CNT_BW-1:0] iter_i,
   input  logic [ACC_BW-1:0] mac_i,
   input  logic [MUL_BW-1:0] var_i,
   input  logic [MUL_BW-1:0] x_i,
   input  logic [MUL_BW-1:0] wc_i,
   input  logic [ACC_BW-1:0] o_i,
   output logic [ACC_BW-1:0] mac_o,
   output logic [MUL_BW-1:0] wc_o,
   output logic [ACC_BW-1:0] o_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              ovf_o
);

   localparam int OPW    = INT_BW + FRA_BW + 1;
   localparam int PRD_BW = 2 * OPW;
   localparam int SUM_BW = ACC_BW + 1;

   localparam logic signed [ACC_BW-1:0] Q_MAX = {{(ACC_BW-OPW+1){1'b0}}, {(OPW-1){1'b1}}};
   localparam logic signed [ACC_BW-1:0] Q_MIN = {{(ACC_BW-OPW+1){1'b1}}, {(OPW-1){1'b0}}};

   localparam logic [CNT_BW-1:0] N_MAX = CNT_BW'(ITER_MAX);
   localparam logic [CNT_BW-1:0] N_DIV = CNT_BW'((ITER_MAX < 4) ? ITER_MAX : 4);
   localparam logic [CNT_BW-1:0] N_EXP = CNT_BW'((ITER_MAX < 6) ? ITER_MAX : 6);
   localparam logic [CNT_BW-1:0] N_LOG = CNT_BW'((ITER_MAX < 8) ? ITER_MAX : 8);

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   function automatic logic signed [OPW-1:0] top_bits(input logic [MUL_BW-1:0] s);
      return s[MUL_BW-1 -: OPW];
   endfunction

   function automatic logic [ACC_BW-1:0] sat(input logic [SUM_BW-1:0] s);
      if (s[SUM_BW-1] != s[SUM_BW-2]) begin
         return s[SUM_BW-1] ? {1'b1, {(ACC_BW-1){1'b0}}} : {1'b0, {(ACC_BW-1){1'b1}}};
      end
      return s[ACC_BW-1:0];
   endfunction

   state_e                    state_q, state_d;
   logic signed [ACC_BW-1:0]  acc_q, acc_d;
   logic signed [OPW-1:0]     vreg_q, vreg_d;
   logic [CNT_BW-1:0]         cnt_q, cnt_d;
   logic                      flag_q, flag_d;
   logic [ACC_BW-1:0]         mac_q, mac_d;
   logic [ACC_BW-1:0]         oreg_q, oreg_d;
   logic                      done_q, done_d;
   logic                      ovf_q, ovf_d;
   logic [MUL_BW-1:0]         wreg_q, ireg_q;

   logic signed [PRD_BW-1:0]  g_prod, u_prod;
   logic signed [SUM_BW-1:0]  g_sum, u_sum, u_coef;
   logic signed [ACC_BW-1:0]  acc_sh;
   logic signed [OPW-1:0]     q_op;
   logic                      q_clamp, u_clamp;
   logic [ACC_BW-1:0]         g_sat, u_sat;
   logic [CNT_BW-1:0]         n_def, n_sel;
   logic                      unused_bits;

   assign unused_bits = ^{var_i[MUL_BW-OPW-1:0], ireg_q[MUL_BW-OPW-1:0]};

   // GEMM datapath
   always_comb begin
      g_prod = PRD_BW'(top_bits(wreg_q)) * PRD_BW'(top_bits(ireg_q));
      g_sum  = SUM_BW'(g_prod) + SUM_BW'(signed'(o_i));
      g_sat  = sat(g_sum);
   end

   // Horner datapath: requantise acc to an operand, multiply by v, add the aligned coefficient
   always_comb begin
      acc_sh  = acc_q >>> FRA_BW;
      q_clamp = 1'b0;
      q_op    = acc_sh[OPW-1:0];
      if (acc_sh > Q_MAX) begin
         q_op    = Q_MAX[OPW-1:0];
         q_clamp = 1'b1;
      end else if (acc_sh < Q_MIN) begin
         q_op    = Q_MIN[OPW-1:0];
         q_clamp = 1'b1;
      end
      u_prod  = PRD_BW'(q_op) * PRD_BW'(vreg_q);
      u_coef  = SUM_BW'(signed'(wc_i)) <<< FRA_BW;
      u_sum   = SUM_BW'(u_prod) + u_coef;
      u_clamp = u_sum[SUM_BW-1] != u_sum[SUM_BW-2];
      u_sat   = sat(u_sum);
   end

   always_comb begin
      unique case (gemm_uno)
         2'b01:   n_def = N_DIV;
         2'b10:   n_def = N_EXP;
         default: n_def = N_LOG;
      endcase
      if (iter_i == '0)         n_sel = n_def;
      else if (iter_i > N_MAX)  n_sel = N_MAX;
      else                      n_sel = iter_i;
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      vreg_d  = vreg_q;
      cnt_d   = cnt_q;
      flag_d  = flag_q;
      mac_d   = mac_q;
      oreg_d  = oreg_q;
      done_d  = 1'b0;
      ovf_d   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (gemm_uno == 2'b00) begin
               oreg_d = g_sat;
            end else if (start_i) begin
               state_d = StRun;
               acc_d   = signed'(mac_i);
               vreg_d  = top_bits(var_i);
               cnt_d   = n_sel;
               flag_d  = 1'b0;
            end
         end
         StRun: begin
            acc_d  = signed'(u_sat);
            flag_d = flag_q | q_clamp | u_clamp;
            cnt_d  = cnt_q - CNT_BW'(1);
            if (cnt_q == CNT_BW'(1)) begin
               state_d = StIdle;
               mac_d   = u_sat;
               done_d  = 1'b1;
               ovf_d   = flag_d;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         acc_q   <= '0;
         vreg_q  <= '0;
         cnt_q   <= '0;
         flag_q  <= 1'b0;
         mac_q   <= '0;
         oreg_q  <= '0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
         wreg_q  <= '0;
         ireg_q  <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         vreg_q  <= vreg_d;
         cnt_q   <= cnt_d;
         flag_q  <= flag_d;
         mac_q   <= mac_d;
         oreg_q  <= oreg_d;
         done_q  <= done_d;
         ovf_q   <= ovf_d;
         wreg_q  <= wc_i;
         ireg_q  <= x_i;
      end
   end

   assign mac_o  = mac_q;
   assign wc_o   = wreg_q;
   assign o_o    = oreg_q;
   assign busy_o = (state_q == StRun);
   assign done_o = done_q;
   assign ovf_o  = ovf_q;

endmodule
